// File: rtl/clk_div_pkg.sv
// Shared types and packet-width helpers for the clock divider bank.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } chan_state_e;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int pkt_width(input int num_ch, input int div_w);
    return ch_width(num_ch) + div_w;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: pending divisor, OFF/LOW/HIGH FSM and phase counter.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             div_clk_o,
  output logic             sync_o
);

  chan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             sync_q, sync_d;

  // A write landing in the same cycle as a decision point is seen at once,
  // so the newest value always wins over an older pending one.
  logic             eff_vld;
  logic [DIV_W-1:0] eff_div;
  logic             last;

  assign eff_vld = wr_i | pend_vld_q;
  assign eff_div = wr_i ? wr_div_i : pend_q;
  assign last    = (cnt_q == (div_q - DIV_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      div_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      sync_q     <= sync_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = eff_div;
    pend_vld_d = eff_vld;
    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (eff_vld) begin
          pend_vld_d = 1'b0;
          if (eff_div != '0) begin
            state_d = ST_LOW;
            div_d   = eff_div;
          end
        end
      end
      ST_LOW: begin
        if (last) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_HIGH: begin
        // End of the high phase is the only point a new divisor may take effect.
        if (last) begin
          cnt_d   = '0;
          state_d = ST_LOW;
          if (eff_vld) begin
            pend_vld_d = 1'b0;
            if (eff_div == '0) begin
              state_d = ST_OFF;
            end else begin
              div_d = eff_div;
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    clk_d  = (state_d == ST_HIGH);
    sync_d = clk_d & ~clk_q;
  end

  assign div_clk_o = clk_q;
  assign sync_o    = sync_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers configured through a serial packet port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en_i,
  input  logic              cfg_data_i,
  output logic [NUM_CH-1:0] div_clk_o,
  output logic [NUM_CH-1:0] sync_o,
  output logic              err_o
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int PKT_W = pkt_width(NUM_CH, DIV_W);
  localparam int BC_W  = $clog2(PKT_W + 2);

  logic [PKT_W-1:0]  shift_q, shift_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              en_q;
  logic              err_q, err_d;
  logic [CH_W-1:0]   pkt_ch;
  logic [DIV_W-1:0]  pkt_div;
  logic              commit;
  logic              pkt_ok;
  logic [NUM_CH-1:0] wr;

  // Packet bits arrive MSB first while cfg_en_i is high; the first low cycle
  // afterwards is the commit cycle that judges and dispatches the packet.
  assign pkt_ch  = shift_q[PKT_W-1 -: CH_W];
  assign pkt_div = shift_q[DIV_W-1:0];
  assign commit  = en_q & ~cfg_en_i;
  assign pkt_ok  = (bcnt_q == BC_W'(PKT_W)) &&
                   ({1'b0, pkt_ch} < (CH_W + 1)'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcnt_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      en_q    <= cfg_en_i;
      err_q   <= err_d;
    end
  end

  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    wr      = '0;
    if (cfg_en_i) begin
      shift_d = {shift_q[PKT_W-2:0], cfg_data_i};
      if (bcnt_q != BC_W'(PKT_W + 1)) bcnt_d = bcnt_q + BC_W'(1);
    end else if (commit) begin
      bcnt_d = '0;
      if (!pkt_ok) err_d = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        wr[i] = pkt_ok && (pkt_ch == CH_W'(i));
      end
    end
  end

  assign err_o = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_i     (wr[g]),
      .wr_div_i (pkt_div),
      .div_clk_o(div_clk_o[g]),
      .sync_o   (sync_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a 4-channel and a 3-channel instance share the config port.
module tb_clk_div_bank;

  localparam int INF = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_en;
  logic       cfg_data;
  logic [3:0] dclk4, sync4;
  logic       err4;
  logic [2:0] dclk3, sync3;
  logic       err3;

  always #5 clk = ~clk;

  clk_div_bank #(.NUM_CH(4), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en_i(cfg_en), .cfg_data_i(cfg_data),
    .div_clk_o(dclk4), .sync_o(sync4), .err_o(err4)
  );

  clk_div_bank #(.NUM_CH(3), .DIV_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_en_i(cfg_en), .cfg_data_i(cfg_data),
    .div_clk_o(dclk3), .sync_o(sync3), .err_o(err3)
  );

  int cyc;
  int n_cmp;
  int n_err;

  // Waveform model per instance/channel: a running segment (start, divisor)
  // and an optional scheduled change at boundary m_b to divisor m_d2 (0 = off).
  int m_on  [2][4];
  int m_s   [2][4];
  int m_d   [2][4];
  int m_b   [2][4];
  int m_d2  [2][4];
  int m_err_from [2];

  logic [8:0] exp_q[$];

  function automatic int val(input int n, input int c, input int k);
    if (m_on[n][c] == 0) return 0;
    if (k >= m_b[n][c]) return (m_d2[n][c] == 0) ? 0 : ((k - m_b[n][c]) / m_d2[n][c]) % 2;
    if (k < m_s[n][c]) return 0;
    return ((k - m_s[n][c]) / m_d[n][c]) % 2;
  endfunction

  function automatic logic [8:0] predict(input int n, input int k);
    logic [3:0] ck, sy;
    for (int c = 0; c < 4; c++) begin
      ck[c] = (val(n, c, k) == 1);
      sy[c] = ck[c] && (val(n, c, k - 1) == 0);
    end
    return {(k >= m_err_from[n]), sy, ck};
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_err_from[n] = INF;
      for (int c = 0; c < 4; c++) begin
        m_on[n][c] = 0; m_s[n][c] = 0; m_d[n][c] = 1; m_b[n][c] = INF; m_d2[n][c] = 0;
      end
    end
  endtask

  task automatic sched(input int n, input int cc, input int ch, input int d, input bit len_ok);
    int numch;
    int per;
    int m;
    numch = (n == 0) ? 4 : 3;
    if (!len_ok || ch >= numch) begin
      if (m_err_from[n] == INF) m_err_from[n] = cc + 1;
      return;
    end
    if (m_b[n][ch] <= cc) begin
      m_s[n][ch]  = m_b[n][ch];
      m_d[n][ch]  = m_d2[n][ch];
      m_on[n][ch] = (m_d2[n][ch] != 0) ? 1 : 0;
      m_b[n][ch]  = INF;
    end
    if (m_b[n][ch] != INF) begin
      m_d2[n][ch] = d;
      return;
    end
    if (m_on[n][ch] == 0) begin
      if (d != 0) begin
        m_on[n][ch] = 1; m_s[n][ch] = cc + 1; m_d[n][ch] = d;
      end
    end else begin
      per = 2 * m_d[n][ch];
      m = (cc + 1 - m_s[n][ch] + per - 1) / per;
      if (m < 1) m = 1;
      m_b[n][ch]  = m_s[n][ch] + m * per;
      m_d2[n][ch] = d;
    end
  endtask

  task automatic check_now();
    logic [8:0] e;
    logic [8:0] act4, act3;
    exp_q.push_back(predict(0, cyc));
    exp_q.push_back(predict(1, cyc));
    act4 = {err4, sync4, dclk4};
    act3 = {err3, 1'b0, sync3, 1'b0, dclk3};
    e = exp_q.pop_front();
    n_cmp++;
    assert (act4 === e) else begin
      n_err++;
      $error("FAIL dut4 cyc=%0d observed=%b expected=%b", cyc, act4, e);
    end
    e = exp_q.pop_front();
    n_cmp++;
    assert (act3 === e) else begin
      n_err++;
      $error("FAIL dut3 cyc=%0d observed=%b expected=%b", cyc, act3, e);
    end
  endtask

  task automatic tick_check();
    @(posedge clk);
    cyc++;
    #1;
    check_now();
  endtask

  task automatic idle(input int n);
    repeat (n) tick_check();
  endtask

  task automatic send_bits(input int nbits, input logic [15:0] pat);
    for (int i = nbits - 1; i >= 0; i--) begin
      cfg_en   = 1'b1;
      cfg_data = pat[i];
      tick_check();
    end
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
    for (int n = 0; n < 2; n++) begin
      sched(n, cyc, int'(pat[9:8]), int'(pat[7:0]), nbits == 10);
    end
    tick_check();
  endtask

  task automatic send_pkt(input int ch, input int d);
    logic [15:0] p;
    p = 16'((ch << 8) | d);
    send_bits(10, p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0;
    rst_n = 1'b0; cfg_en = 1'b0; cfg_data = 1'b0;
    model_reset();
    #1;
    check_now();
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // ch1 div 3: period 6, first rise 4 cycles after commit
    send_pkt(1, 3);
    idle(14);

    // ch0 div 3 then div 5 committed mid-high: change waits for the boundary
    send_pkt(0, 3);
    send_pkt(0, 5);
    idle(24);

    // ch3 is valid on the 4-channel bank, dropped on the 3-channel bank
    send_pkt(3, 2);
    send_pkt(2, 2);
    idle(12);

    // ch2 to div 4, then div 0 stops it after the high phase
    send_pkt(2, 4);
    idle(20);
    send_pkt(2, 0);
    idle(24);
    send_pkt(2, 0);
    idle(10);

    // back-to-back divisor updates on ch1
    send_pkt(1, 7);
    idle(16);
    send_pkt(1, 2);
    send_pkt(1, 5);
    idle(30);

    // malformed packet lengths
    send_bits(9, 16'h01A5);
    idle(4);
    send_bits(11, 16'h02F3);
    idle(8);

    // reset in the middle of a packet
    for (int i = 0; i < 6; i++) begin
      cfg_en   = 1'b1;
      cfg_data = 1'($urandom_range(0, 1));
      tick_check();
    end
    rst_n  = 1'b0;
    cfg_en = 1'b0;
    model_reset();
    #1;
    check_now();
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_pkt(3, 1);
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
